// File: rtl/lab2_proc_div_pkg.sv
// rtl/lab2_proc_div_pkg.sv - shared encodings and helpers for the iterative divider
package lab2_proc_div_pkg;

  localparam logic [1:0] FN_DIV  = 2'd0;
  localparam logic [1:0] FN_DIVU = 2'd1;
  localparam logic [1:0] FN_REM  = 2'd2;
  localparam logic [1:0] FN_REMU = 2'd3;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/lab2_proc_iter_div_unit_dpath.sv
// rtl/lab2_proc_iter_div_unit_dpath.sv - operand, partial remainder and result registers
// Restoring division, one quotient bit per step, with sign fix on the last step.
module lab2_proc_iter_div_unit_dpath
  import lab2_proc_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        finish,
  input  logic [1:0]  fn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        special,
  output logic [31:0] result
);

  logic        is_signed;
  logic        is_rem_in;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic        overflow;
  logic [31:0] special_result;

  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        q_neg;
  logic        r_neg;
  logic        is_rem;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  assign is_signed = (fn == FN_DIV) || (fn == FN_REM);
  assign is_rem_in = (fn == FN_REM) || (fn == FN_REMU);
  assign a_neg     = is_signed && a[31];
  assign b_neg     = is_signed && b[31];
  assign b_zero    = (b == 32'd0);
  assign overflow  = is_signed && (a == INT_MIN) && (b == ALL_ONES);
  assign special   = b_zero || overflow;

  // Divide-by-zero takes priority; the remainder reports the raw dividend.
  always_comb begin
    special_result = 32'd0;
    if (b_zero)
      special_result = is_rem_in ? a : ALL_ONES;
    else
      special_result = is_rem_in ? 32'd0 : INT_MIN;
  end

  // The partial remainder is always below the divisor, so 33 bits cannot overflow.
  assign shifted  = {rem, quo[31]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = !diff[32];
  assign rem_next = fits ? diff[31:0] : shifted[31:0];
  assign quo_next = {quo[30:0], fits};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      is_rem  <= 1'b0;
      result  <= 32'd0;
    end else if (load) begin
      is_rem  <= is_rem_in;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      rem     <= 32'd0;
      quo     <= neg_if(a, a_neg);
      divisor <= neg_if(b, b_neg);
      if (special)
        result <= special_result;
    end else if (step) begin
      rem <= rem_next;
      quo <= quo_next;
      if (finish)
        result <= is_rem ? neg_if(rem_next, r_neg) : neg_if(quo_next, q_neg);
    end
  end

endmodule

// File: rtl/lab2_proc_iter_div_unit.sv
// rtl/lab2_proc_iter_div_unit.sv - iterative DIV/DIVU/REM/REMU unit with val/rdy interfaces
// Control FSM and step counter; arithmetic lives in the dpath.
module lab2_proc_iter_div_unit
  import lab2_proc_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [1:0]  req_fn,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg
);

  state_t      state;
  logic [4:0]  count;
  logic        accept;
  logic        special;
  logic        step;
  logic        finish;

  assign req_rdy  = (state == IDLE) && !reset;
  assign resp_val = (state == DONE);
  assign accept   = req_val && req_rdy;
  assign step     = (state == CALC);
  assign finish   = step && (count == 5'd0);

  lab2_proc_iter_div_unit_dpath u_dpath (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .step    (step),
    .finish  (finish),
    .fn      (req_fn),
    .a       (req_a),
    .b       (req_b),
    .special (special),
    .result  (resp_msg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (special) begin
              state <= DONE;
            end else begin
              state <= CALC;
              count <= 5'd31;
            end
          end
        end
        CALC: begin
          count <= count - 5'd1;
          if (count == 5'd0)
            state <= DONE;
        end
        DONE: begin
          if (resp_rdy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_proc_iter_div_unit.sv
// tb/tb_lab2_proc_iter_div_unit.sv - self-checking bench for the iterative divider
module tb_lab2_proc_iter_div_unit;
  import lab2_proc_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [1:0]  req_fn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int vectors = 0;
  int miscompares = 0;
  int n_resp = 0;
  int n_acc = 0;
  logic [31:0] exp_q[$];
  logic        hold_valid = 1'b0;
  logic [31:0] hold_msg = 32'd0;
  logic        rand_done;

  lab2_proc_iter_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_fn   (req_fn),
    .req_a    (req_a),
    .req_b    (req_b),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (b == 32'd0)
      return (f == FN_DIV || f == FN_DIVU) ? 32'hFFFF_FFFF : a;
    if (f == FN_DIVU) return a / b;
    if (f == FN_REMU) return a % b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (f == FN_DIV) ? 32'(sa / sb) : 32'(sa % sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted request queues its model result; every handshake pops one.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && resp_val) check("hold_stable", resp_msg, hold_msg);
      if (resp_val) check("rdy_excl", {31'd0, req_rdy}, 32'd0);
      if (resp_val && resp_rdy) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_resp: got %h expected none", resp_msg);
        end else begin
          check("resp", resp_msg, exp_q.pop_front());
        end
        n_resp++;
      end
      if (req_val && req_rdy) begin
        exp_q.push_back(model(req_fn, req_a, req_b));
        n_acc++;
      end
      hold_valid = resp_val && !resp_rdy;
      hold_msg = resp_msg;
    end
  end

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!req_rdy && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_rdy) check("req_rdy_timeout", {31'd0, req_rdy}, 32'd1);
    req_val = 1'b1;
    req_fn = f;
    req_a = a;
    req_b = b;
    @(posedge clk); #1;
    req_val = 1'b0;
    req_fn = 2'($urandom);
    req_a = $urandom;
    req_b = $urandom;
  endtask

  task automatic expect_resp(input string name, input logic [31:0] exp, input int lat);
    int k;
    k = 1;
    while (!resp_val && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'(lat));
    check(name, resp_msg, exp);
  endtask

  task automatic handshake();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  logic [1:0]  d_fn  [10] = '{FN_DIVU, FN_REMU, FN_DIV, FN_REM, FN_DIV,
                              FN_DIVU, FN_REMU, FN_DIV, FN_REM, FN_REM};
  logic [31:0] d_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7};
  logic [31:0] d_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
  logic [31:0] d_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd1};
  int          d_lat [10] = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 33};

  initial begin
    int k;
    int resp_base;
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        rose;

    reset = 1'b1;
    req_val = 1'b0;
    req_fn = 2'd0;
    req_a = 32'd0;
    req_b = 32'd0;
    resp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("rst_resp_msg", resp_msg, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      check("model_pin", model(d_fn[i], d_a[i], d_b[i]), d_exp[i]);
      issue(d_fn[i], d_a[i], d_b[i]);
      expect_resp("directed", d_exp[i], d_lat[i]);
      handshake();
    end

    // Back-pressure with a competing request presented during the stall.
    issue(FN_DIVU, 32'hFFFF_FFFF, 32'd1);
    expect_resp("stall_first", 32'hFFFF_FFFF, 33);
    req_val = 1'b1;
    req_fn = FN_DIVU;
    req_a = 32'd200;
    req_b = 32'd10;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_req_rdy", {31'd0, req_rdy}, 32'd0);
      check("stall_msg", resp_msg, 32'hFFFF_FFFF);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    check("after_hs_req_rdy", {31'd0, req_rdy}, 32'd1);
    check("after_hs_resp_val", {31'd0, resp_val}, 32'd0);
    @(posedge clk); #1;
    req_val = 1'b0;
    expect_resp("stall_second", 32'd20, 33);
    handshake();

    // Reset in CALC cycle 10 discards the operation.
    issue(FN_DIVU, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("midrst_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("midrst_resp_val", {31'd0, resp_val}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_after_req_rdy", {31'd0, req_rdy}, 32'd1);
    resp_rdy = 1'b1;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      rose = rose | resp_val;
    end
    resp_rdy = 1'b0;
    check("midrst_no_resp", {31'd0, rose}, 32'd0);
    issue(FN_DIVU, 32'd81, 32'd9);
    expect_resp("after_rst", 32'd9, 33);
    handshake();

    // Random stream against the scoreboard with random back-pressure.
    resp_base = n_resp;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          f = 2'($urandom);
          a = $urandom;
          b = $urandom;
          case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 1000);
            default: ;
          endcase
          issue(f, a, b);
        end
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
          @(posedge clk); #1;
          k++;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          resp_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    resp_rdy = 1'b0;
    check("rand_resp_count", 32'(n_resp - resp_base), 32'd1000);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lab2_proc_iter_div_unit.md
# lab2_proc_iter_div_unit

Iterative 32-bit integer divide/remainder unit for the lab2 processor's execute stage. It implements the RISC-V M-extension DIV, DIVU, REM and REMU operations, which the single-cycle ALU does not cover. The processor issues requests over a val/rdy request interface and drains results over a val/rdy response interface. One operation is in flight at a time, using restoring division at one quotient bit per cycle.

## Interface
Parameters: none. Width is fixed at 32.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `req_val` input 1: request valid.
- `req_rdy` output 1: unit can accept a request.
- `req_fn` input 2: operation select; encodings in the package.
- `req_a` input 32: dividend.
- `req_b` input 32: divisor.
- `resp_val` output 1: result valid.
- `resp_rdy` input 1: consumer accepts the result.
- `resp_msg` output 32: quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `req_rdy`=1 and `resp_val`=0.
  - On `req_val`&&`req_rdy`, latch fn, a and b.
  - If the request is a special case, compute the result directly and go to DONE. Otherwise go to CALC with the 5-bit counter set to 31.
- **Signed ops (DIV, REM)**
  - Operate on the absolute values of a and b.
  - Record quotient sign = sign(a) XOR sign(b); record remainder sign = sign(a).
- **Unsigned ops (DIVU, REMU)**: use a and b unchanged.
- **Special cases (resolved at accept time, no CALC)**
  - b==0: quotient = 0xFFFFFFFF; remainder = a.
  - DIV or REM with a==0x80000000 and b==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **CALC (one restoring step per cycle)**
  - Form {rem[31:0], quo[31]} as the shifted 33-bit partial remainder, then trial-subtract the divisor, computed 33 bits wide.
  - If the result is non-negative, keep the difference and shift in quotient bit 1. Otherwise keep the shifted value and shift in 0.
  - Decrement the counter each cycle.
  - On the step where the counter is 0, apply the sign fix (two's-complement negate where the recorded sign is set), load the 32-bit result register and go to DONE.
- **DONE**
  - `resp_val`=1, `req_rdy`=0, `resp_msg` = result register.
  - Go to IDLE when `resp_rdy`=1; hold otherwise.
- Results are truncated to 32 bits. Remainder magnitude is always less than |b|.

## Timing
- **Reset values**
  - While `reset` is asserted: state=IDLE, result register=0, counter=0, `resp_val`=0, `resp_msg`=0.
  - `req_rdy`=0 while reset is asserted (gated by `reset`); it becomes 1 in the first cycle after deassertion.
- **Latency**
  - Normal ops: accept edge E0, CALC in cycles 1..32, `resp_val` high from cycle 33.
  - Special cases: `resp_val` high in cycle 1.
- **Throughput**
  - The response handshake edge returns the unit to IDLE; the next request can be accepted in the following cycle.
  - No same-cycle response-to-request bypass. Minimum request spacing is 34 cycles for normal ops and 2 cycles for special cases.
- **Back-pressure**: `resp_msg` holds stable while DONE persists with `resp_rdy`=0.
- **Request inputs**: `req_fn`, `req_a` and `req_b` are sampled only on the accept edge and may change freely afterwards.
- **Reset mid-operation**: asserting `reset` during CALC or DONE forces IDLE immediately. The in-flight result is discarded and no response is produced.
- **Outputs**: `req_rdy` and `resp_val` are pure functions of state (and `reset`), with no combinational path from `req_val` or `resp_rdy`.

## Structure
- Package `lab2_proc_div_pkg`:
  - fn encodings DIV=2'd0, DIVU=2'd1, REM=2'd2, REMU=2'd3.
  - State enum {IDLE, CALC, DONE}.
- Natural split: control FSM and counter stay in the top module. One sub-module, `lab2_proc_iter_div_unit_dpath`, holds the operand/partial-remainder registers, the subtractor, the sign-fix negators and the result register, and takes load/step/finish controls.

## Test plan
- DIVU a=100, b=7 → `resp_msg`=14 with `resp_val` rising 33 cycles after accept. REMU with the same operands → 2.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). DIV a=7, b=0xFFFFFFFE → 0xFFFFFFFD.
- DIVU a=5, b=0 → 0xFFFFFFFF in cycle 1. REMU a=5, b=0 → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF, with `resp_rdy` held low for 10 cycles:
  - `resp_msg` stays stable and `req_rdy` stays 0 throughout.
  - A request presented during the stall is not accepted until one cycle after the response handshake.
- Reset asserted for 1 cycle in CALC cycle 10 → `resp_val` never rises and `req_rdy` is 1 after reset. A following DIVU 81/9 returns 9.
- Random stream of 1000 mixed fn/operand requests with random `resp_rdy` → every result matches the golden model and no result is dropped or duplicated.
